// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the image SRAM arbiter.
// Requester slots: sample storage, RC4 stage, edge-detect writer.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    COMPLETE
  } state_t;

  localparam int REQ_SI  = 0;
  localparam int REQ_RC4 = 1;
  localparam int REQ_ED  = 2;

  localparam int NUM_REQ_D = 3;
  localparam int ADDR_W_D  = 20;
  localparam int DATA_W_D  = 32;

  function automatic int wrap_inc(
    input int i,
    input int n
  );
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester and SRAM-side signal bundle of the arbiter.
// master = requesters plus SRAM model, slave = arbiter.
interface sram_access_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_wen;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        err;
  logic [DATA_W-1:0]         rdata;
  logic                      sram_en;
  logic                      sram_wen;
  logic [ADDR_W-1:0]         sram_addr;
  logic [DATA_W-1:0]         sram_wdata;
  logic [DATA_W-1:0]         sram_rdata;
  logic                      busy;

  modport master (
    output req, req_wen, req_addr,
    output req_wdata, sram_rdata,
    input  gnt, done, err, rdata,
    input  sram_en, sram_wen,
    input  sram_addr, sram_wdata, busy
  );

  modport slave (
    input  req, req_wen, req_addr,
    input  req_wdata, sram_rdata,
    output gnt, done, err, rdata,
    output sram_en, sram_wen,
    output sram_addr, sram_wdata, busy
  );
endinterface

// File: rtl/sram_access_arbiter_picker.sv
// Round-robin pick: first requester at or after rr_ptr.
// Offsets are scanned far-to-near so the nearest one wins.
module rr_priority_picker #(
  parameter int NUM_REQ = 3,
  parameter int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               valid,
  output logic [IW-1:0]      idx
);
  int p;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    p     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      p = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[p]) begin
        valid = 1'b1;
        idx   = IW'(p);
      end
    end
  end
endmodule

// File: rtl/sram_access_arbiter.sv
// Single-outstanding round-robin arbiter for the image SRAM.
// All outputs are registered from next-state values.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_D,
  parameter int ADDR_W   = ADDR_W_D,
  parameter int DATA_W   = DATA_W_D,
  parameter int SRAM_LAT = 2,
  parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
  input logic            clk,
  input logic            rst,
  sram_access_arbiter_if.slave bus
);
  localparam int IW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       rr_ptr, rr_ptr_d;
  logic                wen_q, wen_d;
  logic [2:0]          lat_cnt, lat_cnt_d;
  logic                pick_valid;
  logic [IW-1:0]       pick_idx;
  logic [ADDR_W-1:0]   addr_in;
  logic [NUM_REQ-1:0]  gnt_d, done_d, err_d;
  logic [DATA_W-1:0]   rdata_d, wdata_d;
  logic                en_d, swen_d;
  logic [ADDR_W-1:0]   saddr_d;

  rr_priority_picker #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_pick (
    .req   (bus.req),
    .rr_ptr(rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign addr_in =
    bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];

  always_comb begin
    state_d   = state;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr;
    wen_d     = wen_q;
    lat_cnt_d = lat_cnt;
    gnt_d     = '0;
    done_d    = '0;
    err_d     = '0;
    rdata_d   = '0;
    en_d      = 1'b0;
    swen_d    = 1'b0;
    saddr_d   = bus.sram_addr;
    wdata_d   = bus.sram_wdata;
    unique case (state)
      IDLE: if (pick_valid) begin
        idx_d = pick_idx;
        wen_d = bus.req_wen[pick_idx];
        // Out-of-range addresses never touch the SRAM.
        if (addr_in > MAX_ADDR) begin
          state_d         = COMPLETE;
          err_d[pick_idx] = 1'b1;
        end else begin
          state_d         = ACCESS;
          gnt_d[pick_idx] = 1'b1;
          en_d            = 1'b1;
          swen_d          = wen_d;
          saddr_d         = addr_in;
          wdata_d         = bus.req_wdata[
            int'(pick_idx)*DATA_W +: DATA_W];
        end
      end
      ACCESS: begin
        lat_cnt_d = 3'(SRAM_LAT - 1);
        if (SRAM_LAT == 1) begin
          state_d       = COMPLETE;
          done_d[idx_q] = 1'b1;
          rdata_d = wen_q ? '0 : bus.sram_rdata;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        lat_cnt_d = lat_cnt - 3'd1;
        if (lat_cnt == 3'd1) begin
          state_d       = COMPLETE;
          done_d[idx_q] = 1'b1;
          rdata_d = wen_q ? '0 : bus.sram_rdata;
        end
      end
      COMPLETE: begin
        rr_ptr_d = IW'(wrap_inc(int'(idx_q), NUM_REQ));
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx_q          <= '0;
      rr_ptr         <= '0;
      wen_q          <= 1'b0;
      lat_cnt        <= '0;
      bus.gnt        <= '0;
      bus.done       <= '0;
      bus.err        <= '0;
      bus.rdata      <= '0;
      bus.sram_en    <= 1'b0;
      bus.sram_wen   <= 1'b0;
      bus.sram_addr  <= '0;
      bus.sram_wdata <= '0;
      bus.busy       <= 1'b0;
    end else begin
      state          <= state_d;
      idx_q          <= idx_d;
      rr_ptr         <= rr_ptr_d;
      wen_q          <= wen_d;
      lat_cnt        <= lat_cnt_d;
      bus.gnt        <= gnt_d;
      bus.done       <= done_d;
      bus.err        <= err_d;
      bus.rdata      <= rdata_d;
      bus.sram_en    <= en_d;
      bus.sram_wen   <= swen_d;
      bus.sram_addr  <= saddr_d;
      bus.sram_wdata <= wdata_d;
      bus.busy       <= (state_d != IDLE);
    end
  end
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench: dut_a is the default build, dut_b has
// a 64 KiB address limit and single-cycle SRAM latency.
module tb_sram_access_arbiter;
  logic tb_clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 tb_clk = ~tb_clk;

  sram_access_arbiter_if #(
    .NUM_REQ(3), .ADDR_W(20), .DATA_W(32)
  ) ba ();
  sram_access_arbiter_if #(
    .NUM_REQ(3), .ADDR_W(20), .DATA_W(32)
  ) bb ();

  sram_access_arbiter dut_a (
    .clk(tb_clk), .rst(rst), .bus(ba)
  );

  sram_access_arbiter #(
    .SRAM_LAT(1), .MAX_ADDR(20'h0FFFF)
  ) dut_b (
    .clk(tb_clk), .rst(rst), .bus(bb)
  );

  task automatic tick();
    @(negedge tb_clk);
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ba.req = '0; ba.req_wen = '0;
    ba.req_addr = '0; ba.req_wdata = '0;
    ba.sram_rdata = '0;
    bb.req = '0; bb.req_wen = '0;
    bb.req_addr = '0; bb.req_wdata = '0;
    bb.sram_rdata = '0;
    tick();
    tick();
    chk("rst_gnt", ba.gnt, 3'b000);
    chk("rst_done", ba.done, 3'b000);
    chk("rst_err", ba.err, 3'b000);
    chk("rst_en", ba.sram_en, 1'b0);
    chk("rst_busy", ba.busy, 1'b0);
    chk("rst_rdata", ba.rdata, 32'h0);
    rst = 1'b0;

    // single read by requester 0
    ba.sram_rdata = 32'hDEADBEEF;
    ba.req = 3'b001;
    ba.req_addr = {20'h0, 20'h0, 20'h00040};
    tick();
    chk("rd_gnt", ba.gnt, 3'b001);
    chk("rd_en", ba.sram_en, 1'b1);
    chk("rd_wen", ba.sram_wen, 1'b0);
    chk("rd_addr", ba.sram_addr, 20'h00040);
    chk("rd_busy", ba.busy, 1'b1);
    tick();
    chk("rd_wait_en", ba.sram_en, 1'b0);
    chk("rd_wait_gnt", ba.gnt, 3'b000);
    chk("rd_wait_addr", ba.sram_addr, 20'h00040);
    chk("rd_wait_done", ba.done, 3'b000);
    tick();
    chk("rd_done", ba.done, 3'b001);
    chk("rd_rdata", ba.rdata, 32'hDEADBEEF);
    ba.req = 3'b000;
    tick();
    chk("rd_idle_done", ba.done, 3'b000);
    chk("rd_idle_busy", ba.busy, 1'b0);

    // requester 1 aborted by reset in WAIT
    ba.req = 3'b010;
    ba.req_addr = {20'h0, 20'h00100, 20'h0};
    tick();
    chk("ab_gnt", ba.gnt, 3'b010);
    tick();
    chk("ab_wait_en", ba.sram_en, 1'b0);
    rst = 1'b1;
    ba.req = 3'b000;
    tick();
    chk("ab_done", ba.done, 3'b000);
    chk("ab_busy", ba.busy, 1'b0);
    chk("ab_en", ba.sram_en, 1'b0);
    chk("ab_addr", ba.sram_addr, 20'h0);
    chk("ab_gnt0", ba.gnt, 3'b000);
    rst = 1'b0;
    // pointer back at 0: 0 must beat 2
    ba.req = 3'b101;
    ba.req_addr = {20'h00300, 20'h0, 20'h00200};
    tick();
    chk("ab_rr_gnt", ba.gnt, 3'b001);
    chk("ab_rr_addr", ba.sram_addr, 20'h00200);
    tick();
    tick();
    chk("ab_rr_done", ba.done, 3'b001);
    ba.req = 3'b000;
    tick();

    // single write by requester 2
    ba.req = 3'b100;
    ba.req_wen = 3'b100;
    ba.req_addr = {20'h12345, 20'h0, 20'h0};
    ba.req_wdata = {32'hA5A5A5A5, 32'h0, 32'h0};
    tick();
    chk("wr_gnt", ba.gnt, 3'b100);
    chk("wr_en", ba.sram_en, 1'b1);
    chk("wr_wen", ba.sram_wen, 1'b1);
    chk("wr_addr", ba.sram_addr, 20'h12345);
    chk("wr_wdata", ba.sram_wdata, 32'hA5A5A5A5);
    tick();
    chk("wr_wait_en", ba.sram_en, 1'b0);
    tick();
    chk("wr_done", ba.done, 3'b100);
    chk("wr_rdata", ba.rdata, 32'h0);
    ba.req = 3'b000;
    ba.req_wen = 3'b000;
    tick();

    // contention: 0,1,2,0,1,2 every 4 cycles
    ba.req = 3'b111;
    for (int a = 0; a < 6; a++) begin
      tick();
      chk($sformatf("ct_gnt%0d", a),
          ba.gnt, 3'b001 << (a % 3));
      tick();
      chk($sformatf("ct_gap%0d", a), ba.gnt, 3'b000);
      tick();
      chk($sformatf("ct_done%0d", a),
          ba.done, 3'b001 << (a % 3));
      if (a == 5) ba.req = 3'b000;
      tick();
      chk($sformatf("ct_idle%0d", a), ba.gnt, 3'b000);
    end
    chk("ct_end_busy", ba.busy, 1'b0);

    // dut_b: address error on 1, then 2 is served
    bb.sram_rdata = 32'h13572468;
    bb.req = 3'b110;
    bb.req_addr = {20'h00010, 20'hFFFFF, 20'h0};
    tick();
    chk("er_err", bb.err, 3'b010);
    chk("er_gnt", bb.gnt, 3'b000);
    chk("er_en", bb.sram_en, 1'b0);
    chk("er_done", bb.done, 3'b000);
    chk("er_busy", bb.busy, 1'b1);
    bb.req = 3'b100;
    tick();
    chk("er_idle_err", bb.err, 3'b000);
    tick();
    chk("er_nx_gnt", bb.gnt, 3'b100);
    chk("er_nx_addr", bb.sram_addr, 20'h00010);
    tick();
    chk("er_nx_done", bb.done, 3'b100);
    chk("er_nx_rdata", bb.rdata, 32'h13572468);
    bb.req = 3'b000;
    tick();

    // dut_b: one-cycle latency read of address 0
    bb.sram_rdata = 32'hCAFEF00D;
    bb.req = 3'b001;
    bb.req_addr = '0;
    tick();
    chk("l1_gnt", bb.gnt, 3'b001);
    chk("l1_addr", bb.sram_addr, 20'h0);
    chk("l1_early", bb.done, 3'b000);
    tick();
    chk("l1_done", bb.done, 3'b001);
    chk("l1_rdata", bb.rdata, 32'hCAFEF00D);
    chk("l1_en", bb.sram_en, 1'b0);
    bb.req = 3'b000;
    tick();
    chk("l1_busy", bb.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
